// File: rtl/lifo_pkg.sv
// Shared types for the LIFO stack: per-cycle operation classification.
package lifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_SWAP = 2'b11
  } lifo_op_e;

  function automatic lifo_op_e lifo_op(input logic push, input logic pop);
    return lifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/lifo_ram.sv
// Simple dual-port RAM: synchronous write port, registered read port with enable.
module lifo_ram #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wr_en_i,
  input  logic [AWIDTH-1:0] wr_addr_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AWIDTH-1:0] rd_addr_i,
  output logic [DWIDTH-1:0] rd_data_o
);

  localparam int DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the output register is cleared.
  always_ff @(posedge clk_i) begin
    if (wr_en_i)
      mem[wr_addr_i] <= wr_data_i;
  end

  // NOTE: non-blocking assignment means a read of the address being written returns the old word.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i)
      rd_data_o <= '0;
    else if (rd_en_i)
      rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/lifo.sv
// Single-clock LIFO stack with occupancy count and empty/full/almost flags.
module lifo
  import lifo_pkg::*;
#(
  parameter int DWIDTH       = 16,
  parameter int AWIDTH       = 8,
  parameter int ALMOST_FULL  = 2,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wrreq_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              almost_empty_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              full_o,
  output logic [AWIDTH:0]   usedw_o
);

  localparam logic [AWIDTH:0] DEPTH  = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] ONE    = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [AWIDTH:0] AE_LVL = ALMOST_EMPTY[AWIDTH:0];
  localparam logic [AWIDTH:0] AF_LVL = ALMOST_FULL[AWIDTH:0];

  logic [AWIDTH:0]   usedw;
  logic [AWIDTH:0]   usedw_dec;
  logic [AWIDTH:0]   usedw_nxt;
  logic              do_push;
  logic              do_pop;
  lifo_op_e          op;
  logic [AWIDTH-1:0] wr_addr;

  assign usedw_dec = usedw - ONE;

  // A push into a full stack is allowed only when a pop frees the top slot.
  assign do_pop  = rdreq_i & ~empty_o;
  assign do_push = wrreq_i & (~full_o | do_pop);
  assign op      = lifo_op(do_push, do_pop);

  // On a swap the new word replaces the old top, which is read out this edge.
  assign wr_addr = (op == OP_SWAP) ? usedw_dec[AWIDTH-1:0] : usedw[AWIDTH-1:0];

  // NOTE: assign a default before the case so no path leaves usedw_nxt unassigned (no latch).
  always_comb begin
    usedw_nxt = usedw;
    unique case (op)
      OP_PUSH: usedw_nxt = usedw + ONE;
      OP_POP:  usedw_nxt = usedw_dec;
      default: usedw_nxt = usedw;
    endcase
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i)
      usedw <= '0;
    else
      usedw <= usedw_nxt;
  end

  lifo_ram #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH)
  ) u_ram (
    .clk_i     (clk_i),
    .srst_i    (srst_i),
    .wr_en_i   (do_push),
    .wr_addr_i (wr_addr),
    .wr_data_i (data_i),
    .rd_en_i   (do_pop),
    .rd_addr_i (usedw_dec[AWIDTH-1:0]),
    .rd_data_o (q_o)
  );

  assign usedw_o        = usedw;
  assign empty_o        = (usedw == '0);
  assign full_o         = (usedw == DEPTH);
  assign almost_empty_o = (usedw < AE_LVL);
  assign almost_full_o  = (usedw >= AF_LVL);

endmodule

// File: tb/tb_lifo.sv
// Directed, table-driven bench for the lifo stack (default 16x256, thresholds 2).
module tb_lifo;

  logic        clk_i = 1'b0;
  logic        srst_i;
  logic        wrreq_i;
  logic [15:0] data_i;
  logic        rdreq_i;
  logic [15:0] q_o;
  logic        almost_empty_o;
  logic        empty_o;
  logic        almost_full_o;
  logic        full_o;
  logic [8:0]  usedw_o;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] data;
    logic [15:0] q;
    logic [8:0]  usedw;
  } vec_t;

  vec_t vecs[$];

  lifo dut (
    .clk_i          (clk_i),
    .srst_i         (srst_i),
    .wrreq_i        (wrreq_i),
    .data_i         (data_i),
    .rdreq_i        (rdreq_i),
    .q_o            (q_o),
    .almost_empty_o (almost_empty_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .full_o         (full_o),
    .usedw_o        (usedw_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {empty, almost_empty, almost_full, full} for thresholds of 2 and depth 256.
  function automatic logic [3:0] exp_flags(input int u);
    return {u == 0, u < 2, u >= 2, u == 256};
  endfunction

  task automatic check_state(input string name, input logic [15:0] q, input int u);
    check({name, ".q"}, q_o, q);
    check({name, ".usedw"}, usedw_o, u);
    check({name, ".flags"}, {empty_o, almost_empty_o, almost_full_o, full_o}, exp_flags(u));
  endtask

  // One operation: drive at negedge, sample 1 time unit after the rising edge.
  task automatic step(input logic wr, input logic rd, input logic [15:0] d);
    @(negedge clk_i);
    wrreq_i = wr;
    rdreq_i = rd;
    data_i  = d;
    @(posedge clk_i);
    #1;
    wrreq_i = 1'b0;
    rdreq_i = 1'b0;
  endtask

  function automatic vec_t mk(input logic wr, input logic rd, input logic [15:0] d,
                              input logic [15:0] q, input logic [8:0] u);
    vec_t v;
    v.wr = wr; v.rd = rd; v.data = d; v.q = q; v.usedw = u;
    return v;
  endfunction

  initial begin
    srst_i  = 1'b1;
    wrreq_i = 1'b0;
    rdreq_i = 1'b0;
    data_i  = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check_state("reset", 16'h0000, 0);
    @(negedge clk_i);
    srst_i = 1'b0;

    // Small sequence, pop on empty, swap on empty, swap with two words.
    for (int i = 1; i <= 10; i++) vecs.push_back(mk(1, 0, 16'(i), 16'h0000, 9'(i)));
    for (int i = 1; i <= 10; i++) vecs.push_back(mk(0, 1, 16'h0, 16'(11 - i), 9'(10 - i)));
    vecs.push_back(mk(0, 1, 16'h0000, 16'h0001, 0));
    vecs.push_back(mk(1, 1, 16'h00D0, 16'h0001, 1));
    vecs.push_back(mk(0, 1, 16'h0000, 16'h00D0, 0));
    vecs.push_back(mk(1, 0, 16'h00A0, 16'h00D0, 1));
    vecs.push_back(mk(1, 0, 16'h00B0, 16'h00D0, 2));
    vecs.push_back(mk(1, 1, 16'h00C0, 16'h00B0, 2));
    vecs.push_back(mk(0, 1, 16'h0000, 16'h00C0, 1));
    vecs.push_back(mk(0, 1, 16'h0000, 16'h00A0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].data);
      check_state($sformatf("vec%0d", i), vecs[i].q, int'(vecs[i].usedw));
    end

    // Fill past capacity: words 257..300 are dropped.
    for (int i = 1; i <= 300; i++) begin
      step(1, 0, 16'(i));
      check_state($sformatf("fill%0d", i), 16'h00A0, (i > 256) ? 256 : i);
    end

    // Swap while full reads the old top and keeps the count.
    step(1, 1, 16'hBEEF);
    check_state("swap_full", 16'h0100, 256);
    step(0, 1, 16'h0000);
    check_state("pop_beef", 16'hBEEF, 255);
    step(1, 0, 16'h0100);
    check_state("refill", 16'hBEEF, 256);

    // Drain past empty: extra pops hold the last word.
    for (int k = 1; k <= 300; k++) begin
      step(0, 1, 16'h0000);
      check_state($sformatf("drain%0d", k), (k <= 256) ? 16'(257 - k) : 16'h0001,
                  (k <= 256) ? 256 - k : 0);
    end

    // Reset between edges clears count and q immediately.
    for (int i = 1; i <= 5; i++) step(1, 0, 16'(16'h0050 + i));
    step(0, 1, 16'h0000);
    check_state("pre_rst", 16'h0055, 4);
    @(negedge clk_i);
    #2;
    srst_i = 1'b1;
    #1;
    check_state("mid_rst", 16'h0000, 0);
    @(negedge clk_i);
    srst_i = 1'b0;
    step(1, 0, 16'h00E0);
    check_state("post_rst_push", 16'h0000, 1);
    step(0, 1, 16'h0000);
    check_state("post_rst_pop", 16'h00E0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lifo.md
Name: lifo

Overview:
Single-clock last-in-first-out stack buffer of 2**AWIDTH words of DWIDTH bits, with occupancy count and empty/full/almost flags. It sits between a producer that pushes with wrreq_i and a consumer that pops with rdreq_i. Its handshake and flag set mirror the team's single-clock FIFO, but its ordering is stack (LIFO).

Parameters:
DWIDTH, 16, data word width in bits.
AWIDTH, 8, address width; depth = 2**AWIDTH words (256 by default).
ALMOST_FULL, 2, occupancy threshold for almost_full_o.
ALMOST_EMPTY, 2, occupancy threshold for almost_empty_o.

Ports:
clk_i  in  1  single clock; all state changes on the rising edge.
srst_i  in  1  reset, asynchronous and active-high.
wrreq_i  in  1  push request; data_i is sampled on the same edge.
data_i  in  DWIDTH  push data.
rdreq_i  in  1  pop request.
q_o  out  DWIDTH  popped word, registered.
almost_empty_o  out  1  usedw_o < ALMOST_EMPTY.
empty_o  out  1  usedw_o == 0.
almost_full_o  out  1  usedw_o >= ALMOST_FULL.
full_o  out  1  usedw_o == 2**AWIDTH.
usedw_o  out  AWIDTH+1  number of stored words, 0..2**AWIDTH.

Behaviour:
- Reset (async, srst_i=1): usedw_o=0, q_o=0, empty_o=1, almost_empty_o=1 (when ALMOST_EMPTY>0), full_o=0, almost_full_o=0 (when ALMOST_FULL>0). Memory contents are not cleared.
- Reset mid-operation discards all stored words immediately; the first edge after deassertion behaves as on an empty stack.
- Storage: array mem[0..2**AWIDTH-1]. The stack pointer equals usedw; the top of stack is mem[usedw-1].
- Push only (wrreq_i=1, rdreq_i=0, not full): mem[usedw] <= data_i; usedw increments. Push while full is ignored: no state change, no error.
- Pop only (rdreq_i=1, wrreq_i=0, not empty): q_o <= mem[usedw-1]; usedw decrements. Latency 1: q_o is valid the cycle after the edge that sampled rdreq_i.
- Pop while empty is ignored; q_o holds its previous value.
- q_o holds its value on every cycle without a successful pop.
- Push and pop in the same cycle, not empty: q_o <= mem[usedw-1] (the old top); mem[usedw-1] <= data_i; usedw unchanged. This also applies when full.
- Push and pop in the same cycle, empty: behaves as push only; q_o unchanged.
- Flags are combinational decodes of the registered usedw, so they update in the same cycle as usedw_o. There is no write-to-flag bypass.
- usedw arithmetic uses AWIDTH+1 bits; it never wraps below 0 or above 2**AWIDTH.
- No internal pipelining beyond the q_o register; sustained one operation per clock.

Decomposition:
- Shared package (lifo_pkg): none required for RTL. Derived constant DEPTH = 2**AWIDTH is local. The verification test_case enum (SOME_RW, FULL_RW, OVER_RW, BIG_TEST) belongs in the verification package, not RTL.
- One natural sub-module: lifo_ram, a simple dual-port RAM.
  - Write port: address, data, enable.
  - Read port: registered, with read enable.
  - The top level keeps the usedw counter, address muxing (write address = usedw, or usedw-1 on simultaneous push/pop) and the flag decode.
- Verification side: lifo_if interface carrying all non-clock ports, and a lifo_enviroment class (generator/driver/monitor/scoreboard with a reference queue model).

Test Plan:
- Small random: push 10 values (0x0001..0x000A), then pop 10 -> q_o = 0x000A down to 0x0001, one cycle after each rdreq_i; usedw_o goes 10→0; empty_o=1 at the end.
- Fill and drain: push 256 words -> full_o=1 and usedw_o=256 after the 256th edge; almost_full_o=1 once usedw_o>=2; pop 256 -> reverse order, empty_o=1.
- Overflow/underflow: push 300 words -> usedw_o stays 256, words 257..300 are dropped. Pop 300 -> first q_o = word 256, last valid = word 1; extra pops leave q_o = word 1 and usedw_o=0.
- Simultaneous: with stack [A,B] (B on top), rd+wr with data C -> q_o=B, usedw_o stays 2; the next pop returns C.
- Simultaneous on empty: rd+wr with data D -> usedw_o=1, q_o unchanged; the next pop returns D.
- Reset mid-stream: after 5 pushes, assert srst_i between edges -> usedw_o=0, empty_o=1, q_o=0 immediately; a following push of E then pop returns E.
